// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared widths, helpers and field record for the posit decoder
package posit_pkg;

  localparam int POSIT_N  = 32;
  localparam int POSIT_ES = 2;

  function automatic int posit_rs_w(input int n);
    return $clog2(n);
  endfunction

  // A zero-width exponent still gets a 1-bit port that is tied low.
  function automatic int posit_exp_w(input int es);
    return (es > 0) ? es : 1;
  endfunction

  function automatic int posit_scale_w(input int n, input int es);
    return $clog2(n) + es + 1;
  endfunction

  localparam int POSIT_RS = posit_rs_w(POSIT_N);
  localparam int POSIT_EW = posit_exp_w(POSIT_ES);
  localparam int POSIT_SW = posit_scale_w(POSIT_N, POSIT_ES);

  typedef struct packed {
    logic                sign;
    logic [POSIT_RS:0]   k;
    logic [POSIT_EW-1:0] exp;
    logic [POSIT_SW-1:0] scale;
    logic [POSIT_N-1:0]  mant;
    logic                nar;
    logic                zero;
  } posit_fields_t;

endpackage

// File: rtl/posit_decode_pipe_if.sv
// rtl/posit_decode_pipe_if.sv - operand stream in, decoded field stream out
interface posit_decode_pipe_if
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES
);
  localparam int RS = posit_rs_w(N);
  localparam int EW = posit_exp_w(ES);
  localparam int SW = posit_scale_w(N, ES);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [RS:0]   out_k;
  logic [EW-1:0] out_exp;
  logic [SW-1:0] out_scale;
  logic [N-1:0]  out_mant;
  logic          out_nar;
  logic          out_zero;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_k, out_exp, out_scale, out_mant, out_nar, out_zero
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_k, out_exp, out_scale, out_mant, out_nar, out_zero
  );
endinterface

// File: rtl/posit_regime_lzd.sv
// rtl/posit_regime_lzd.sv - leading-run counter giving regime polarity and run length
module posit_regime_lzd #(
  parameter  int N  = 32,
  localparam int RS = $clog2(N)
) (
  input  logic [N-2:0]  bits,
  output logic          pol,
  output logic [RS-1:0] run
);
  logic done;

  always_comb begin
    pol  = bits[N-2];
    run  = '0;
    done = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!done && (bits[i] == pol)) run = run + RS'(1);
      else                           done = 1'b1;
    end
  end
endmodule

// File: rtl/posit_decode_pipe.sv
// rtl/posit_decode_pipe.sv - two-stage valid/ready posit field decoder
module posit_decode_pipe
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES
) (
  input  logic                clk,
  input  logic                rst,
  posit_decode_pipe_if.slave  bus
);
  localparam int RS = posit_rs_w(N);
  localparam int EW = posit_exp_w(ES);
  localparam int SW = posit_scale_w(N, ES);

  typedef struct packed {
    logic          sign;
    logic          nar;
    logic          zero;
    logic          r0;
    logic [RS-1:0] m;
    logic [N-2:0]  rem;
  } s1_t;

  typedef struct packed {
    logic          sign;
    logic [RS:0]   k;
    logic [EW-1:0] exp;
    logic [SW-1:0] scale;
    logic [N-1:0]  mant;
    logic          nar;
    logic          zero;
  } fields_t;

  logic    v1_q, v1_d, v2_q, v2_d;
  s1_t     s1_q, s1_d, s1_in;
  fields_t f2_q, f2_d, f2_calc;
  logic    ready_s1, ready_s2;

  logic [N-2:0]     body;
  logic             r0_in;
  logic [RS-1:0]    m_in;
  logic [RS:0]      sh;
  logic [N-2:0]     shifted;
  logic [RS:0]      k_u;
  logic signed [RS:0]   k_s;
  logic signed [SW-1:0] k_ext;
  logic [EW-1:0]    exp_calc;

  // Stage 1: sign split, two's-complement magnitude, regime run length.
  assign body = bus.in_data[N-2:0];

  always_comb begin
    s1_in      = '0;
    s1_in.sign = bus.in_data[N-1];
    s1_in.nar  = bus.in_data[N-1] && (body == '0);
    s1_in.zero = !bus.in_data[N-1] && (body == '0);
    s1_in.rem  = bus.in_data[N-1] ? (~body + 1'b1) : body;
    s1_in.r0   = r0_in;
    s1_in.m    = m_in;
  end

  posit_regime_lzd #(.N(N)) u_lzd (
    .bits (s1_in.rem),
    .pol  (r0_in),
    .run  (m_in)
  );

  // Stage 2: drop regime run plus terminator; a saturated run shifts everything out.
  assign sh      = {1'b0, s1_q.m} + (RS+1)'(1);
  assign shifted = s1_q.rem << sh;
  assign k_u     = s1_q.r0 ? ({1'b0, s1_q.m} - (RS+1)'(1)) : ((RS+1)'(0) - {1'b0, s1_q.m});
  assign k_s     = k_u;
  assign k_ext   = SW'(k_s);

  if (ES > 0) begin : g_exp
    assign exp_calc = shifted[N-2 -: EW];
  end else begin : g_no_exp
    assign exp_calc = 1'b0;
  end

  always_comb begin
    f2_calc      = '0;
    f2_calc.sign = s1_q.sign;
    f2_calc.nar  = s1_q.nar;
    f2_calc.zero = s1_q.zero;
    if (!(s1_q.nar || s1_q.zero)) begin
      f2_calc.k     = k_u;
      f2_calc.exp   = exp_calc;
      f2_calc.scale = SW'(k_ext <<< ES) + SW'(exp_calc);
      f2_calc.mant  = {1'b1, shifted << ES};
    end
  end

  always_comb begin
    ready_s2 = !v2_q || bus.out_ready;
    ready_s1 = !v1_q || ready_s2;
    v1_d     = v1_q;
    v2_d     = v2_q;
    s1_d     = s1_q;
    f2_d     = f2_q;
    if (ready_s1) v1_d = bus.in_valid;
    if (ready_s1 && bus.in_valid) s1_d = s1_in;
    if (ready_s2) v2_d = v1_q;
    if (ready_s2 && v1_q) f2_d = f2_calc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      s1_q <= '0;
      f2_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      s1_q <= s1_d;
      f2_q <= f2_d;
    end
  end

  assign bus.in_ready  = ready_s1;
  assign bus.out_valid = v2_q;
  assign bus.out_sign  = f2_q.sign;
  assign bus.out_k     = f2_q.k;
  assign bus.out_exp   = f2_q.exp;
  assign bus.out_scale = f2_q.scale;
  assign bus.out_mant  = f2_q.mant;
  assign bus.out_nar   = f2_q.nar;
  assign bus.out_zero  = f2_q.zero;
endmodule

// File: tb/tb_posit_decode_pipe.sv
// tb/tb_posit_decode_pipe.sv - directed and scoreboarded checks of the posit decoder
module tb_posit_decode_pipe;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  posit_decode_pipe_if #(.N(8),  .ES(1)) bus8  ();
  posit_decode_pipe_if #(.N(32), .ES(2)) bus32 ();

  posit_decode_pipe #(.N(8),  .ES(1)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
  posit_decode_pipe #(.N(32), .ES(2)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [50:0] q[$];
  logic [31:0] vec[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] got8();
    return {bus8.out_sign, bus8.out_k, bus8.out_exp, bus8.out_scale, bus8.out_mant, bus8.out_nar, bus8.out_zero};
  endfunction

  function automatic logic [50:0] got32();
    return {bus32.out_sign, bus32.out_k, bus32.out_exp, bus32.out_scale, bus32.out_mant, bus32.out_nar, bus32.out_zero};
  endfunction

  // Bit-serial reference decode for N=32, ES=2.
  function automatic logic [50:0] model32(input logic [31:0] x);
    logic [31:0] a, mant;
    logic        s, r0;
    int          run, i, k, e, pos;
    if (x == 32'h0) return {1'b0, 48'd0, 1'b0, 1'b1};
    if (x == 32'h8000_0000) return {1'b1, 48'd0, 1'b1, 1'b0};
    s   = x[31];
    a   = s ? (~x + 32'd1) : x;
    r0  = a[30];
    run = 0;
    i   = 30;
    while (i >= 0 && a[i] == r0) begin
      run++;
      i--;
    end
    k = r0 ? run - 1 : -run;
    i--;
    e = 0;
    for (int j = 0; j < 2; j++) begin
      e = e * 2 + ((i >= 0) ? int'(a[i]) : 0);
      i--;
    end
    mant = 32'h8000_0000;
    pos  = 30;
    while (i >= 0) begin
      mant[pos] = a[i];
      pos--;
      i--;
    end
    return {s, 6'(k), 2'(e), 8'(k * 4 + e), mant, 2'b00};
  endfunction

  task automatic run8(input string tag, input logic [7:0] x, input logic [20:0] exp_f);
    @(negedge clk);
    bus8.in_valid  = 1'b1;
    bus8.in_data   = x;
    bus8.out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, bus8.in_ready, 1);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    #1 check({tag, "_lat1"}, bus8.out_valid, 0);
    @(negedge clk);
    #1 check({tag, "_lat2"}, bus8.out_valid, 1);
    check(tag, got8(), exp_f);
  endtask

  task automatic step32(input logic iv, input logic [31:0] d, input logic ordy,
                        output logic acc, output logic ov);
    @(negedge clk);
    bus32.in_valid  = iv;
    bus32.in_data   = d;
    bus32.out_ready = ordy;
    #1;
    acc = iv && bus32.in_ready;
    ov  = bus32.out_valid;
    if (acc) q.push_back(model32(d));
    if (ov && ordy) begin
      if (q.size() == 0) check("r32_extra", 1, 0);
      else check("r32", got32(), q.pop_front());
    end
  endtask

  localparam logic [20:0] E56 = {1'b0, 4'd0,    1'b1, 5'd1,     8'hB0, 2'b00};
  localparam logic [20:0] EAA = {1'b1, 4'd0,    1'b1, 5'd1,     8'hB0, 2'b00};
  localparam logic [20:0] E01 = {1'b0, 4'b1010, 1'b0, 5'b10100, 8'h80, 2'b00};
  localparam logic [20:0] E7F = {1'b0, 4'd6,    1'b0, 5'd12,    8'h80, 2'b00};
  localparam logic [20:0] E80 = {1'b1, 4'd0,    1'b0, 5'd0,     8'h00, 2'b10};
  localparam logic [20:0] E00 = {1'b0, 4'd0,    1'b0, 5'd0,     8'h00, 2'b01};
  localparam logic [20:0] E40 = {1'b0, 4'd0,    1'b0, 5'd0,     8'h80, 2'b00};
  localparam logic [20:0] E20 = {1'b0, 4'b1111, 1'b0, 5'b11110, 8'h80, 2'b00};
  localparam logic [20:0] E60 = {1'b0, 4'd1,    1'b0, 5'd2,     8'h80, 2'b00};

  initial begin
    logic acc, ov;
    int   idx, cyc, stalls, gaps, stale;
    rst = 1'b1;
    bus8.in_valid   = 1'b0;
    bus8.in_data    = '0;
    bus8.out_ready  = 1'b1;
    bus32.in_valid  = 1'b0;
    bus32.in_data   = '0;
    bus32.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus8.out_valid, 0);
    check("rst_in_ready", bus8.in_ready, 1);
    check("rst_fields", got8(), 0);
    rst = 1'b0;

    run8("v56", 8'h56, E56);
    run8("vAA", 8'hAA, EAA);
    run8("v01", 8'h01, E01);
    run8("v7F", 8'h7F, E7F);
    run8("v80", 8'h80, E80);
    run8("v00", 8'h00, E00);
    run8("v40", 8'h40, E40);
    run8("v20", 8'h20, E20);
    run8("v60", 8'h60, E60);

    // Backpressure: two accepts then stall with outputs frozen.
    @(negedge clk);
    bus8.out_ready = 1'b0;
    bus8.in_valid  = 1'b1;
    bus8.in_data   = 8'h56;
    #1 check("bp_acc1", bus8.in_ready, 1);
    @(negedge clk);
    bus8.in_data = 8'h01;
    #1 check("bp_acc2", bus8.in_ready, 1);
    @(negedge clk);
    bus8.in_data = 8'h7F;
    #1 check("bp_full", bus8.in_ready, 0);
    check("bp_valid", bus8.out_valid, 1);
    check("bp_hold0", got8(), E56);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 check("bp_stall", bus8.in_ready, 0);
      check("bp_frozen", got8(), E56);
    end
    @(negedge clk);
    bus8.out_ready = 1'b1;
    #1 check("bp_release", bus8.in_ready, 1);
    check("bp_out0", got8(), E56);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    #1 check("bp_v1", bus8.out_valid, 1);
    check("bp_out1", got8(), E01);
    @(negedge clk);
    #1 check("bp_v2", bus8.out_valid, 1);
    check("bp_out2", got8(), E7F);
    @(negedge clk);
    #1 check("bp_empty", bus8.out_valid, 0);

    // Asynchronous reset with two operands in flight.
    @(negedge clk);
    bus8.out_ready = 1'b0;
    bus8.in_valid  = 1'b1;
    bus8.in_data   = 8'h56;
    @(negedge clk);
    bus8.in_data = 8'h01;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    #1 check("ar_pre_valid", bus8.out_valid, 1);
    #2 rst = 1'b1;
    #1 check("ar_valid", bus8.out_valid, 0);
    check("ar_fields", got8(), 0);
    @(negedge clk);
    rst = 1'b0;
    bus8.out_ready = 1'b1;
    #1 check("ar_in_ready", bus8.in_ready, 1);
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 if (bus8.out_valid) stale++;
    end
    check("ar_no_stale", stale, 0);

    // N=32 sweep against the reference decoder under random flow control.
    vec.push_back(32'h8000_0000);
    vec.push_back(32'h0000_0000);
    vec.push_back(32'h7FFF_FFFF);
    vec.push_back(32'h0000_0001);
    vec.push_back(32'hFFFF_FFFF);
    vec.push_back(32'h8000_0001);
    vec.push_back(32'h4000_0000);
    vec.push_back(32'hC000_0000);
    for (int r = 0; r < 4; r++) begin
      vec.push_back(32'h7FFF_FFFF >> r);
      vec.push_back(32'h0000_0001 << r);
    end
    for (int i = 0; i < 200; i++) vec.push_back($urandom);

    idx = 0;
    cyc = 0;
    while ((idx < vec.size() || q.size() != 0) && cyc < 3000) begin
      step32((idx < vec.size()) && ($urandom_range(3) != 0),
             (idx < vec.size()) ? vec[idx] : 32'h0,
             $urandom_range(3) != 0, acc, ov);
      if (acc) idx++;
      cyc++;
    end
    check("r32_drain", q.size(), 0);
    check("r32_sent", idx, vec.size());

    stalls = 0;
    gaps   = 0;
    for (int i = 0; i < 40; i++) begin
      step32(1'b1, $urandom, 1'b1, acc, ov);
      if (!acc) stalls++;
      if (i >= 2 && !ov) gaps++;
    end
    for (int i = 0; i < 3; i++) step32(1'b0, 32'h0, 1'b1, acc, ov);
    check("tp_stalls", stalls, 0);
    check("tp_gaps", gaps, 0);
    check("tp_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
